// File: rtl/pdm_cic_decimator_if.sv
// Signal bundle between a PDM bit source and the CIC decimator.
interface pdm_cic_decimator_if #(
    parameter int OUT_WIDTH = 16
);
    // Both directions are strobe-only (no ready): PDM_data is consumed in the
    // cycle PDM_valid is high; PCM_data/Clip are meaningful while PCM_valid is
    // high and then held until the next PCM_valid.
    logic                 PDM_data;
    logic                 PDM_valid;
    logic [OUT_WIDTH-1:0] PCM_data;
    logic                 PCM_valid;
    logic                 Clip;

    modport master (
        output PDM_data, PDM_valid,
        input  PCM_data, PCM_valid, Clip
    );

    modport slave (
        input  PDM_data, PDM_valid,
        output PCM_data, PCM_valid, Clip
    );
endinterface

// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator (M=1) turning a strobed 1-bit PDM stream into
// saturated signed PCM; integrators at strobe rate, combs at frame rate.
module pdm_cic_decimator #(
    parameter int LOG2_DEC  = 6,
    parameter int OUT_WIDTH = 16
) (
    input  logic                  Clock_100MHz,
    input  logic                  Reset,
    pdm_cic_decimator_if.slave    bus
);
    localparam int ACC_W = 3 * LOG2_DEC + 2;
    localparam int SHIFT = ACC_W - 1 - OUT_WIDTH;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {2'b00, {(ACC_W-2){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {2'b11, {(ACC_W-2){1'b0}}};
    localparam logic [OUT_WIDTH-1:0]    PCM_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]    PCM_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic signed [ACC_W-1:0] cin_q, cin_d;
    logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic signed [ACC_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [LOG2_DEC-1:0]     cnt_q, cnt_d;
    logic [3:0]              stg_q, stg_d;
    logic [OUT_WIDTH-1:0]    pcm_q, pcm_d;
    logic                    pcm_valid_q, pcm_valid_d;
    logic                    clip_q, clip_d;
    logic signed [ACC_W-1:0] x;
    logic                    e0;

    always_comb begin
        x           = bus.PDM_data ? ACC_W'(1) : {ACC_W{1'b1}};
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        cnt_d       = cnt_q;
        cin_d       = cin_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        c3_d        = c3_q;
        pcm_d       = pcm_q;
        clip_d      = clip_q;
        pcm_valid_d = stg_q[3];
        e0          = bus.PDM_valid && (cnt_q == {LOG2_DEC{1'b1}});
        stg_d       = {stg_q[2:0], e0};

        // Cascade uses each stage's freshly updated value in the same cycle.
        if (bus.PDM_valid) begin
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_d;
            i3_d  = i3_q + i2_d;
            cnt_d = cnt_q + LOG2_DEC'(1);
        end

        if (e0) cin_d = i3_d;

        if (stg_q[0]) begin
            c1_d = cin_q - d1_q;
            d1_d = cin_q;
        end
        if (stg_q[1]) begin
            c2_d = c1_q - d2_q;
            d2_d = c1_q;
        end
        if (stg_q[2]) begin
            c3_d = c2_q - d3_q;
            d3_d = c2_q;
        end

        // Positive full scale (+R^3) is one past the representable range.
        if (stg_q[3]) begin
            if (c3_q > SAT_MAX) begin
                pcm_d  = PCM_MAX;
                clip_d = 1'b1;
            end else if (c3_q < SAT_MIN) begin
                pcm_d  = PCM_MIN;
                clip_d = 1'b0;
            end else begin
                pcm_d  = c3_q[SHIFT +: OUT_WIDTH];
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            cnt_q       <= '0;
            cin_q       <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            stg_q       <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c3_q        <= c3_d;
            stg_q       <= stg_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            clip_q      <= clip_d;
        end
    end

    assign bus.PCM_data  = pcm_q;
    assign bus.PCM_valid = pcm_valid_q;
    assign bus.Clip      = clip_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: full-scale, periodic patterns,
// output timing against strobe count, and asynchronous reset behaviour.
module tb_pdm_cic_decimator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pdm_cic_decimator_if #(.OUT_WIDTH(16)) bus ();

    pdm_cic_decimator #(.LOG2_DEC(6), .OUT_WIDTH(16)) dut (
        .Clock_100MHz (clk),
        .Reset        (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    int          strobe_cnt = 0;
    logic [31:0] exp_q[$];
    logic [15:0] got_pcm[$];
    logic        got_clip[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every 64th accepted strobe must yield a PCM_valid seen right after edge +4.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            strobe_cnt = 0;
            exp_q.delete();
        end else if (bus.PDM_valid) begin
            strobe_cnt++;
            if (strobe_cnt % 64 == 0) exp_q.push_back(32'(edge_cnt + 4));
        end
    end

    always @(negedge clk) begin
        if (bus.PCM_valid) begin
            got_pcm.push_back(bus.PCM_data);
            got_clip.push_back(bus.Clip);
            if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
            else                   check("valid_edge", 32'(edge_cnt), exp_q.pop_front());
        end
    end

    task automatic drive_strobes(input logic [3:0] pat, input bit rnd, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.PDM_valid = 1'b1;
            bus.PDM_data  = rnd ? 1'($urandom_range(0, 1)) : pat[3 - (i % 4)];
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                bus.PDM_valid = 1'b0;
                bus.PDM_data  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        bus.PDM_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.PDM_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_got();
        got_pcm.delete();
        got_clip.delete();
    endtask

    task automatic run_pattern(input string name, input logic [3:0] pat, input int gap,
                               input logic [15:0] exp_pcm, input logic exp_clip);
        apply_reset();
        clear_got();
        drive_strobes(pat, 1'b0, 256, gap);
        repeat (8) @(negedge clk);
        check($sformatf("%s_count", name), 32'(got_pcm.size()), 32'd4);
        check($sformatf("%s_pending", name), 32'(exp_q.size()), 32'd0);
        for (int s = 2; s < 4; s++) begin
            check($sformatf("%s_pcm%0d", name, s + 1), 32'(got_pcm[s]), 32'(exp_pcm));
            check($sformatf("%s_clip%0d", name, s + 1), 32'(got_clip[s]), 32'(exp_clip));
        end
    endtask

    initial begin
        bus.PDM_valid = 1'b0;
        bus.PDM_data  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pcm", 32'(bus.PCM_data), 32'h0);
        check("rst_valid", 32'(bus.PCM_valid), 32'h0);
        check("rst_clip", 32'(bus.Clip), 32'h0);
        rst = 1'b0;

        run_pattern("ones42", 4'b1111, 42, 16'h7FFF, 1'b1);

        // Partial random frame, then asynchronous reset between clock edges.
        drive_strobes(4'b0000, 1'b1, 30, 42);
        check("hold_pcm", 32'(bus.PCM_data), 32'h7FFF);
        check("hold_clip", 32'(bus.Clip), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_pcm", 32'(bus.PCM_data), 32'h0);
        check("async_valid", 32'(bus.PCM_valid), 32'h0);
        check("async_clip", 32'(bus.Clip), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_got();
        drive_strobes(4'b0000, 1'b1, 63, 42);
        repeat (8) @(negedge clk);
        check("post_rst_63", 32'(got_pcm.size()), 32'd0);
        drive_strobes(4'b0000, 1'b1, 1, 42);
        repeat (8) @(negedge clk);
        check("post_rst_64", 32'(got_pcm.size()), 32'd1);

        run_pattern("zeros42", 4'b0000, 42, 16'h8000, 1'b0);
        run_pattern("alt42", 4'b1010, 42, 16'h0000, 1'b0);
        run_pattern("r1110", 4'b1110, 42, 16'h4000, 1'b0);
        run_pattern("ones_cont", 4'b1111, 1, 16'h7FFF, 1'b1);

        // One-cycle reset at strobe 30 of frame 5; that frame must vanish.
        apply_reset();
        clear_got();
        drive_strobes(4'b1111, 1'b0, 4 * 64 + 29, 3);
        check("f5_pre_count", 32'(got_pcm.size()), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        bus.PDM_valid = 1'b1;
        bus.PDM_data  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.PDM_valid = 1'b0;
        clear_got();
        drive_strobes(4'b1111, 1'b0, 192, 3);
        repeat (8) @(negedge clk);
        check("f5_post_count", 32'(got_pcm.size()), 32'd3);
        check("f5_pending", 32'(exp_q.size()), 32'd0);
        check("f5_pcm3", 32'(got_pcm[2]), 32'h7FFF);
        check("f5_clip3", 32'(got_clip[2]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
Downstream of the PDM microphone interface. Consumes the 1-bit PDM stream (one channel's demultiplexed bit plus a per-sample strobe) and converts it to signed PCM with a 3rd-order CIC decimator (differential delay 1). Instantiate once per channel for stereo. Runs entirely on the 100 MHz system clock; the input cadence comes only from the strobe.

Parameters:
LOG2_DEC, 6, log2 of decimation ratio (R = 2^LOG2_DEC = 64); legal range 2..10
OUT_WIDTH, 16, PCM output width; must satisfy OUT_WIDTH <= 3*LOG2_DEC+1

Ports:
Clock_100MHz  input   1          system clock, all logic on rising edge
Reset         input   1          asynchronous, active-high reset
PDM_data      input   1          PDM bit; 1 = +1, 0 = -1
PDM_valid     input   1          one-cycle strobe; PDM_data is sampled when high
PCM_data      output  OUT_WIDTH  signed two's-complement PCM sample
PCM_valid     output  1          one-cycle strobe; PCM_data and Clip are valid
Clip          output  1          current sample was saturated (positive full scale)

Behaviour:
- Internal width: ACC_W = 3*LOG2_DEC + 2 (20 bits by default). All integrators and combs are ACC_W signed. Integrators wrap modulo 2^ACC_W; no overflow detection. The comb differences cancel the wrap exactly.
- Reset, asynchronous, applies in any state, including mid-frame or mid-pipeline:
  - integrators, comb delay registers, comb pipeline, sample counter -> 0
  - PCM_data = 0, PCM_valid = 0, Clip = 0
  - Any in-flight frame is discarded.
- Integrator section (on each clock with PDM_valid = 1):
  - x = +1 if PDM_data else -1
  - I1 += x; I2 += I1_new; I3 += I2_new
  - Cascaded within the same cycle, so each update uses the new value of the previous stage.
  - With PDM_valid = 0, all integrators hold.
- Sample counter: LOG2_DEC bits. Increments on each PDM_valid and wraps from R-1 to 0.
- Decimation edge E0: the clock edge where PDM_valid = 1 and counter = R-1. At E0, I3_new is captured into the comb input register.
- Comb pipeline: one stage per edge.
  - E1: C1 = in - D1, then D1 <= in
  - E2: C2 = C1 - D2, then D2 <= C1
  - E3: C3 = C2 - D3, then D3 <= C2
  - E4: saturate C3 to [-2^(ACC_W-2), 2^(ACC_W-2)-1]. Set Clip = 1 if C3 > 2^(ACC_W-2)-1, else 0. PCM_data = saturated value arithmetically shifted right by (ACC_W-1-OUT_WIDTH), truncated to OUT_WIDTH bits.
  - PCM_valid = 1 for exactly the one cycle following E4.
- PCM_data and Clip hold their values until the next E4.
- Latency: PCM_valid is asserted 4 cycles after the cycle carrying the R-th PDM_valid of a frame.
- Steady-state gain: R^3. Full-scale results with default parameters:
  - all ones -> +2^18 -> saturates -> 0x7FFF, Clip = 1
  - all zeros -> -2^18 -> 0x8000, Clip = 0
- Transient: the first two PCM samples after reset are settling values and are not checked. From the 3rd sample onward, the output is exact for any input that is periodic with a period dividing R.
- PDM_valid may be high on consecutive cycles. Since R >= 4, frames never overlap in the comb pipeline. PDM_valid arriving during E1..E4 feeds the integrators normally.
- PDM_data is ignored when PDM_valid = 0.

Test Plan:
- Reset asserted mid-run with random PDM at 1 strobe / 42 clocks -> PCM_data = 0x0000, PCM_valid = 0, Clip = 0 immediately (asynchronous). After release, no PCM_valid until 64 new strobes have occurred.
- All-ones PDM, 256 strobes at 1 per 42 clocks -> PCM samples 3 and 4 = 0x7FFF with Clip = 1. Each PCM_valid is exactly one cycle wide, asserted 4 clocks after the 64th/128th/... strobe.
- All-zeros PDM, 256 strobes -> samples 3 and 4 = 0x8000, Clip = 0.
- Alternating 1,0,1,0 PDM -> samples 3 and 4 = 0x0000. Repeating 1,1,1,0 -> samples 3 and 4 = 0x4000. Clip = 0 in both cases.
- PDM_valid held high every cycle, all ones -> same values as the 42-clock case. PCM_valid pulses exactly every 64 clocks.
- Reset asserted for 1 cycle at strobe 30 of frame 5 with all-ones input -> the in-flight frame is never output. The next PCM_valid occurs 4 clocks after the 64th post-reset strobe. Sample 3 after reset = 0x7FFF.
